// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive-side TDM demultiplexer.
// A bit-interleaved serial stream (slot 0..3 round-robin, MSB first per slot)
// is split into four WIDTH-bit channel words. All four words are loaded
// together once a full frame of 4*WIDTH valid bits has been received.
// Frame alignment comes from frame_sync_in on frame bit 0.
//
// Input qualification: bit_valid_in is a valid-only strobe with no ready.
// The block accepts every bit offered, so there is no backpressure. When
// bit_valid_in is low, bit_in and frame_sync_in are don't-care, and no counter,
// state or output register changes except for the one-cycle pulses returning
// to zero.
module tdm_demux_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             bit_in,
    input  logic             bit_valid_in,
    input  logic             frame_sync_in,
    output logic [WIDTH-1:0] ch0_out,
    output logic [WIDTH-1:0] ch1_out,
    output logic [WIDTH-1:0] ch2_out,
    output logic [WIDTH-1:0] ch3_out,
    output logic             frame_valid_out,
    output logic             sync_err_out,
    output logic [1:0]       sel_out,
    output logic             locked_out,
    output logic [1:0]       state_dbg_out
);

    localparam int FRAME_BITS = 4 * WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_RECV      = 2'd1,
        ST_WAIT_SYNC = 2'd2
    } state_t;

    state_t           state;
    // Index k of the next frame bit to be accepted; its low two bits are the slot.
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg [4];

    logic             take_start;
    logic             take_bit;
    logic             take_last;
    logic             err_stray;
    logic             err_nosync;
    logic [1:0]       slot;

    assign slot          = bit_cnt[1:0];
    assign sel_out       = slot;
    assign state_dbg_out = state;

    // Decode what the current valid bit does in the present state.
    always_comb begin
        take_start = 1'b0;
        take_bit   = 1'b0;
        take_last  = 1'b0;
        err_stray  = 1'b0;
        err_nosync = 1'b0;
        if (bit_valid_in) begin
            if (frame_sync_in) begin
                // Sync always restarts a frame at k = 0. In RECV the counter is
                // already past bit 0, so a sync there is a misalignment.
                take_start = 1'b1;
                err_stray  = (state == ST_RECV);
            end else begin
                case (state)
                    ST_RECV: begin
                        take_bit  = 1'b1;
                        take_last = (bit_cnt == LAST_K);
                    end
                    ST_WAIT_SYNC: err_nosync = 1'b1;
                    default:      ;
                endcase
            end
        end
    end

    // Alignment FSM, slot shift registers and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_HUNT;
            bit_cnt         <= '0;
            for (int i = 0; i < 4; i++) begin
                shreg[i] <= '0;
            end
            ch0_out         <= '0;
            ch1_out         <= '0;
            ch2_out         <= '0;
            ch3_out         <= '0;
            frame_valid_out <= 1'b0;
            sync_err_out    <= 1'b0;
            locked_out      <= 1'b0;
        end else begin
            frame_valid_out <= 1'b0;
            sync_err_out    <= err_stray | err_nosync;

            if (take_start) begin
                // Bit 0 belongs to slot 0. Clearing the other slots drops any
                // partial frame left behind by a misaligned sync.
                shreg[0]   <= {{(WIDTH-1){1'b0}}, bit_in};
                shreg[1]   <= '0;
                shreg[2]   <= '0;
                shreg[3]   <= '0;
                bit_cnt    <= CNT_W'(1);
                state      <= ST_RECV;
                locked_out <= 1'b1;
            end else if (take_last) begin
                // The last bit is slot 3's LSB. It goes straight into ch3_out;
                // the other words are already complete in their shift registers.
                ch0_out         <= shreg[0];
                ch1_out         <= shreg[1];
                ch2_out         <= shreg[2];
                ch3_out         <= {shreg[3][WIDTH-2:0], bit_in};
                shreg[3]        <= {shreg[3][WIDTH-2:0], bit_in};
                frame_valid_out <= 1'b1;
                bit_cnt         <= '0;
                state           <= ST_WAIT_SYNC;
                locked_out      <= 1'b1;
            end else if (take_bit) begin
                shreg[slot] <= {shreg[slot][WIDTH-2:0], bit_in};
                bit_cnt     <= bit_cnt + CNT_W'(1);
            end else if (err_nosync) begin
                bit_cnt    <= '0;
                state      <= ST_HUNT;
                locked_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed bench for the TDM demultiplexer.
// The reference model keeps the accepted frame bits in a queue and forms the
// channel words by direct bit indexing. The bench compares the outputs with
// the model on every cycle and adds literal checks at the test milestones.
module tb_tdm_demux_1to4;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         bit_in;
    logic         bit_valid_in;
    logic         frame_sync_in;
    logic [W-1:0] ch0_out, ch1_out, ch2_out, ch3_out;
    logic         frame_valid_out;
    logic         sync_err_out;
    logic [1:0]   sel_out;
    logic         locked_out;
    logic [1:0]   state_dbg_out;

    int tests_run = 0;
    int tests_failed = 0;
    int dut_fv_cnt = 0;
    int dut_err_cnt = 0;

    // Reference model state.
    int           mode;            // 0 = hunting, 1 = collecting, 2 = awaiting sync
    logic         bits_q[$];
    logic [W-1:0] exp_ch [4];
    logic         exp_fv;
    logic         exp_err;

    tdm_demux_1to4 #(.WIDTH(W)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .bit_in          (bit_in),
        .bit_valid_in    (bit_valid_in),
        .frame_sync_in   (frame_sync_in),
        .ch0_out         (ch0_out),
        .ch1_out         (ch1_out),
        .ch2_out         (ch2_out),
        .ch3_out         (ch3_out),
        .frame_valid_out (frame_valid_out),
        .sync_err_out    (sync_err_out),
        .sel_out         (sel_out),
        .locked_out      (locked_out),
        .state_dbg_out   (state_dbg_out)
    );

    // Clock generation.
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = 0;
        bits_q.delete();
        for (int i = 0; i < 4; i++) exp_ch[i] = '0;
        exp_fv = 1'b0;
        exp_err = 1'b0;
    endtask

    // Apply one input cycle to the model.
    task automatic model_step(input logic v, input logic s, input logic b);
        exp_fv = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (s) begin
                if (mode == 1) exp_err = 1'b1;
                bits_q.delete();
                bits_q.push_back(b);
                mode = 1;
            end else if (mode == 1) begin
                bits_q.push_back(b);
                if (bits_q.size() == 4 * W) begin
                    for (int k = 0; k < 4 * W; k++)
                        exp_ch[k % 4][W - 1 - k / 4] = bits_q[k];
                    exp_fv = 1'b1;
                    bits_q.delete();
                    mode = 2;
                end
            end else if (mode == 2) begin
                exp_err = 1'b1;
                mode = 0;
            end
        end
    endtask

    // Scoreboard compare against the model; runs once per sampled cycle.
    task automatic check_cycle();
        logic [1:0] exp_sel;
        exp_sel = (mode == 1) ? 2'(bits_q.size() % 4) : 2'd0;
        check("ch0", 32'(ch0_out), 32'(exp_ch[0]));
        check("ch1", 32'(ch1_out), 32'(exp_ch[1]));
        check("ch2", 32'(ch2_out), 32'(exp_ch[2]));
        check("ch3", 32'(ch3_out), 32'(exp_ch[3]));
        check("frame_valid", 32'(frame_valid_out), 32'(exp_fv));
        check("sync_err", 32'(sync_err_out), 32'(exp_err));
        check("sel", 32'(sel_out), 32'(exp_sel));
        check("locked", 32'(locked_out), 32'(mode != 0));
        if (frame_valid_out === 1'b1) dut_fv_cnt++;
        if (sync_err_out === 1'b1) dut_err_cnt++;
    endtask

    // Drive one cycle of inputs, then sample #1 after the rising edge.
    task automatic step(input logic v, input logic s, input logic b);
        bit_valid_in = v;
        frame_sync_in = s;
        bit_in = b;
        @(posedge clk_in);
        model_step(v, s, b);
        #1;
        check_cycle();
    endtask

    task automatic gap_cycle();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Send frame bits k_first .. k_first+n-1 of the four words, sync on k = 0.
    task automatic send_bits(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2, input logic [W-1:0] w3,
                             input int k_first, input int n, input bit gaps);
        logic [W-1:0] words [4];
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        for (int k = k_first; k < k_first + n; k++) begin
            if (gaps) gap_cycle();
            step(1'b1, 1'(k == 0), words[k % 4][W - 1 - k / 4]);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] w3,
                              input bit gaps);
        send_bits(w0, w1, w2, w3, 0, 4 * W, gaps);
    endtask

    task automatic check_words(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1,
                               input logic [W-1:0] w2, input logic [W-1:0] w3);
        check({tag, "_ch0"}, 32'(ch0_out), 32'(w0));
        check({tag, "_ch1"}, 32'(ch1_out), 32'(w1));
        check({tag, "_ch2"}, 32'(ch2_out), 32'(w2));
        check({tag, "_ch3"}, 32'(ch3_out), 32'(w3));
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic apply_reset();
        #2;
        rst_n_in = 1'b0;
        bit_valid_in = 1'b0;
        frame_sync_in = 1'b0;
        bit_in = 1'b0;
        #1;
        model_reset();
        check_cycle();
        @(posedge clk_in);
        #1;
        check_cycle();
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in = 1'b0;
        bit_in = 1'b0;
        bit_valid_in = 1'b0;
        frame_sync_in = 1'b0;
        model_reset();
        #1;
        check_cycle();
        check_words("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // 1: one clean frame, continuous valid.
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0);
        check_words("f1", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        check("f1_fv_count", 32'(dut_fv_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0);

        // 2: same frame with gaps between all bits.
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1);
        check_words("f2", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        check("f2_fv_count", 32'(dut_fv_cnt), 32'd2);

        // 3: back-to-back frames, no error.
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0);
        send_frame(8'h01, 8'h80, 8'h55, 8'hAA, 1'b0);
        check_words("b2b", 8'h01, 8'h80, 8'h55, 8'hAA);
        check("b2b_fv_count", 32'(dut_fv_cnt), 32'd4);
        check("b2b_err_count", 32'(dut_err_cnt), 32'd0);

        // 4: stray sync at k = 13 after a fresh reset.
        apply_reset();
        send_bits(8'hA5, 8'h3C, 8'hFF, 8'h00, 0, 13, 1'b0);
        send_bits(8'h12, 8'h34, 8'h56, 8'h78, 0, 1, 1'b0);
        check("stray_err_count", 32'(dut_err_cnt), 32'd1);
        check("stray_ch0_held", 32'(ch0_out), 32'h0);
        send_bits(8'h12, 8'h34, 8'h56, 8'h78, 1, 4 * W - 1, 1'b0);
        check_words("stray", 8'h12, 8'h34, 8'h56, 8'h78);

        // 5: non-sync bit after a completed frame drops lock.
        step(1'b1, 1'b0, 1'b1);
        check("nosync_err", 32'(sync_err_out), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("nosync_unlocked", 32'(locked_out), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        check("nosync_err_count", 32'(dut_err_cnt), 32'd2);
        check_words("nosync_held", 8'h12, 8'h34, 8'h56, 8'h78);

        // 6: reset at k = 20, then a clean frame.
        send_bits(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 20, 1'b0);
        apply_reset();
        check_words("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst_locked", 32'(locked_out), 32'd0);
        send_frame(8'h0F, 8'hF0, 8'hC3, 8'h3C, 1'b0);
        check_words("post_rst", 8'h0F, 8'hF0, 8'hC3, 8'h3C);
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
